// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op encodings, FSM state type and helpers for alu_seq
package alu_seq_pkg;

    localparam int REG_AW = 3;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOTA = 4'd7,
        ALU_PASA = 4'd8,
        ALU_PASB = 4'd9,
        ALU_SLL  = 4'd10,
        ALU_SRL  = 4'd11,
        ALU_SRA  = 4'd12,
        ALU_INC4 = 4'd13,
        ALU_DEC4 = 4'd14,
        ALU_HAM  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    // Extended Hamming(8,4): bits 0..6 are codeword positions 1..7
    // (p1 p2 d0 p4 d1 d2 d3), bit 7 is overall parity of bits 0..6.
    function automatic logic [7:0] ham_encode(input logic [3:0] d);
        logic [7:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

endpackage

// File: rtl/alu_top.sv
// rtl/alu_top.sv - combinational 16-op N-bit ALU
module alu_top
    import alu_seq_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] y,
    output logic         err
);

    alu_op_e       op_e;
    logic          shamt_big;
    logic [N+7:0]  a_ext;
    logic [N+7:0]  ham_ext;

    assign op_e      = alu_op_e'(op);
    // Shift amounts at or beyond the width saturate rather than wrap
    assign shamt_big = (32'(b) >= N);
    assign a_ext     = {8'b0, a};
    assign ham_ext   = {{N{1'b0}}, ham_encode(a_ext[3:0])};

    // Operation select; every op produces a value, only divide can flag an error
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op_e)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_MUL:  y = a * b;
            ALU_DIV: begin
                if (b == '0) begin
                    y   = '1;
                    err = 1'b1;
                end else begin
                    y = a / b;
                end
            end
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOTA: y = ~a;
            ALU_PASA: y = a;
            ALU_PASB: y = b;
            ALU_SLL:  y = shamt_big ? '0 : (a << b);
            ALU_SRL:  y = shamt_big ? '0 : (a >> b);
            ALU_SRA:  y = shamt_big ? {N{a[N-1]}} : N'($signed(a) >>> b);
            ALU_INC4: y = a + N'(4);
            ALU_DEC4: y = a - N'(4);
            ALU_HAM:  y = ham_ext[N-1:0];
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - four-state sequencer around alu_top with internal register file
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N    = 6,
    parameter int NREG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_imm,
    input  logic [N-1:0]      imm,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_data,
    output logic              res_zero,
    output logic              res_err
);

    state_e              state, state_nx;
    logic                started;
    logic                wb_done;
    logic [3:0]          op_q;
    logic [REG_AW-1:0]   rd_q, rs1_q, rs2_q;
    logic                use_imm_q;
    logic [N-1:0]        imm_q;
    logic [N-1:0]        a_q, b_q;
    logic [N-1:0]        regs [NREG];
    logic [N-1:0]        rs1_val, rs2_val;
    logic [N-1:0]        alu_y;
    logic                alu_err;

    // Out-of-range addresses (only possible when NREG < 8) read as zero
    assign rs1_val = (32'(rs1_q) < NREG) ? regs[rs1_q] : '0;
    assign rs2_val = (32'(rs2_q) < NREG) ? regs[rs2_q] : '0;

    alu_top #(.N(N)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .y   (alu_y),
        .err (alu_err)
    );

    // State register; started keeps in_ready low until the first edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            started <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = started;
                if (in_valid && started) state_nx = READ;
            end
            READ: state_nx = EXEC;
            EXEC: state_nx = WB;
            WB: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Instruction latch, operand fetch, result capture and single write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            wb_done   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_done <= 1'b0;
                    if (in_valid && started) begin
                        op_q      <= op;
                        rd_q      <= rd;
                        rs1_q     <= rs1;
                        rs2_q     <= rs2;
                        use_imm_q <= use_imm;
                        imm_q     <= imm;
                    end
                end
                READ: begin
                    a_q <= rs1_val;
                    b_q <= use_imm_q ? imm_q : rs2_val;
                end
                EXEC: begin
                    res_data <= alu_y;
                    res_zero <= (alu_y == '0);
                    res_err  <= alu_err;
                end
                WB: begin
                    if (!wb_done) begin
                        if (32'(rd_q) < NREG) regs[rd_q] <= res_data;
                        wb_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
